// File: rtl/prio_pkg.sv
// Shared definitions for the priority encoder/arbiter family.
//   PRIO_FIXED / PRIO_RR : values for the MODE parameter
//   clog2_min1           : index width helper, never returns less than 1
package prio_pkg;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_find_first.sv
// Combinational descending search with wrap-around.
//   req   : request vector
//   start : highest-priority index; search runs start, start-1, ..., 0, N-1, ...
//   found : any request set
//   idx   : index of the first set request encountered
//   oh    : one-hot form of idx (all zero when nothing found)
module prio_find_first #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx,
  output logic [N-1:0] oh
);

  logic [N-1:0] rot;
  int unsigned  pos;

  always_comb begin
    // Rotate so that req[start] lands on rot[N-1]; then rot[j] = req[(j+start+1) mod N]
    // and a plain top-down scan of rot gives the wrapped descending order.
    rot   = N'({req, req} >> (32'(start) + 32'd1));
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rot[N-1-i]) begin
        found = 1'b1;
        pos   = (N - 1 - i) + 32'(start) + 1;
        if (pos >= N) pos = pos - N;
        idx   = W'(pos);
      end
    end
    oh = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/prio_arb_enc.sv
// Registered N-input priority encoder / arbiter with valid/ready output.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : level-sensitive request vector
//   ei         : enable input; 0 blocks new selections
//   out_ready  : consumer accepts the current output
//   out_valid  : y/grant hold a valid selection
//   y          : binary index of the granted request
//   grant      : one-hot grant
//   gs         : group select, equal to out_valid
//   eo         : combinational ei & ~|req, enables the next lower stage
// MODE selects fixed priority (index N-1 highest) or round-robin.
module prio_arb_enc
  import prio_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter int unsigned W    = clog2_min1(N),
  parameter int unsigned MODE = PRIO_FIXED
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         ei,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] y,
  output logic [N-1:0] grant,
  output logic         gs,
  output logic         eo
);

  logic [W-1:0] start;
  logic         sel_found;
  logic [W-1:0] sel_idx;
  logic [N-1:0] sel_oh;
  logic         load;

  prio_find_first #(
    .N (N),
    .W (W)
  ) u_find (
    .req   (req),
    .start (start),
    .found (sel_found),
    .idx   (sel_idx),
    .oh    (sel_oh)
  );

  assign load = ei & sel_found & (~out_valid | out_ready);
  assign eo   = ei & ~(|req);
  assign gs   = out_valid;

  if (MODE == PRIO_RR) begin : g_rr
    logic [W-1:0] ptr;

    // After granting k, k becomes lowest priority: search restarts just below it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ptr <= W'(N - 1);
      end else if (load) begin
        ptr <= (sel_idx == '0) ? W'(N - 1) : sel_idx - 1'b1;
      end
    end

    assign start = ptr;
  end else begin : g_fixed
    assign start = W'(N - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      grant     <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      y         <= sel_idx;
      grant     <= sel_oh;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prio_arb_enc.sv
module tb_prio_arb_enc;

  logic        clk;
  logic        rst_n;
  logic        ei;
  logic        out_ready;

  logic [15:0] req16;
  logic        valid16, gs16, eo16;
  logic [3:0]  y16;
  logic [15:0] grant16;

  logic [7:0]  req8;
  logic        valid8, gs8, eo8;
  logic [2:0]  y8;
  logic [7:0]  grant8;

  int checks = 0;
  int errors = 0;

  int exp16_q[$];
  int exp8_q[$];

  prio_arb_enc #(
    .N    (16),
    .MODE (0)
  ) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req16),
    .ei        (ei),
    .out_ready (out_ready),
    .out_valid (valid16),
    .y         (y16),
    .grant     (grant16),
    .gs        (gs16),
    .eo        (eo16)
  );

  prio_arb_enc #(
    .N    (8),
    .MODE (1)
  ) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req8),
    .ei        (ei),
    .out_ready (out_ready),
    .out_valid (valid8),
    .y         (y8),
    .grant     (grant8),
    .gs        (gs8),
    .eo        (eo8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ei = 1'b0; out_ready = 1'b1; req16 = '0; req8 = '0;
    repeat (3) tick();
    checks++;
    if (valid16 !== 1'b0 || y16 !== 4'd0 || grant16 !== 16'h0 || gs16 !== 1'b0) begin
      errors++;
      $display("FAIL reset16: got v=%b y=%0d g=%h gs=%b, want 0 0 0000 0", valid16, y16, grant16, gs16);
    end
    checks++;
    if (valid8 !== 1'b0 || y8 !== 3'd0 || grant8 !== 8'h0 || gs8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: got v=%b y=%0d g=%h gs=%b, want 0 0 00 0", valid8, y8, grant8, gs8);
    end
    rst_n = 1'b1;
    tick();
    ei = 1'b1;
    #1;
    checks++;
    if (eo16 !== 1'b1 || eo8 !== 1'b1 || valid16 !== 1'b0) begin
      errors++;
      $display("FAIL reset_eo: got eo16=%b eo8=%b v16=%b, want 1 1 0", eo16, eo8, valid16);
    end
  endtask

  task automatic test_fixed();
    logic [15:0] pats [4];
    int          idxs [4];
    int          e;
    logic [15:0] g;
    pats[0] = 16'h0421; idxs[0] = 10;
    pats[1] = 16'h8001; idxs[1] = 15;
    pats[2] = 16'h0001; idxs[2] = 0;
    pats[3] = 16'hFFFF; idxs[3] = 15;
    out_ready = 1'b1; ei = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req16 = pats[i];
      exp16_q.push_back(idxs[i]);
      tick();
      checks++;
      if (exp16_q.size() == 0) begin
        errors++;
        $display("FAIL fixed_sb: scoreboard empty");
      end else begin
        e = exp16_q.pop_front();
        g = 16'd1 << e;
        if (y16 !== 4'(e) || grant16 !== g || valid16 !== 1'b1 || gs16 !== 1'b1) begin
          errors++;
          $display("FAIL fixed_sel: got y=%0d g=%h v=%b gs=%b, want y=%0d g=%h v=1 gs=1",
                   y16, grant16, valid16, gs16, e, g);
        end
      end
    end
    req16 = '0;
    tick();
    checks++;
    if (valid16 !== 1'b0 || gs16 !== 1'b0) begin
      errors++;
      $display("FAIL fixed_drain: got v=%b gs=%b, want 0 0", valid16, gs16);
    end
  endtask

  task automatic test_backpressure();
    int          e;
    logic [15:0] g;
    out_ready = 1'b0; ei = 1'b1;
    req16 = 16'h0080;
    exp16_q.push_back(7);
    tick();
    checks++;
    e = exp16_q.pop_front();
    if (y16 !== 4'(e) || valid16 !== 1'b1) begin
      errors++;
      $display("FAIL bp_load: got y=%0d v=%b, want y=%0d v=1", y16, valid16, e);
    end
    req16 = 16'h8000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (y16 !== 4'd7 || grant16 !== 16'h0080 || valid16 !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: got y=%0d g=%h v=%b, want y=7 g=0080 v=1", y16, grant16, valid16);
      end
    end
    out_ready = 1'b1;
    exp16_q.push_back(15);
    tick();
    checks++;
    e = exp16_q.pop_front();
    g = 16'd1 << e;
    if (y16 !== 4'(e) || grant16 !== g || valid16 !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got y=%0d g=%h v=%b, want y=%0d g=%h v=1", y16, grant16, valid16, e, g);
    end
    req16 = '0;
    tick();
    checks++;
    if (valid16 !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got v=%b, want 0", valid16);
    end
  endtask

  task automatic rr_run(input logic [7:0] pattern, input int n);
    int         e;
    logic [7:0] g;
    req8 = pattern;
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("FAIL rr_sb: scoreboard empty");
      end else begin
        e = exp8_q.pop_front();
        g = 8'd1 << e;
        if (y8 !== 3'(e) || grant8 !== g || valid8 !== 1'b1 || gs8 !== 1'b1) begin
          errors++;
          $display("FAIL rr_grant%0d: got y=%0d g=%h v=%b gs=%b, want y=%0d g=%h v=1 gs=1",
                   i, y8, grant8, valid8, gs8, e, g);
        end
      end
    end
    req8 = '0;
    tick();
    checks++;
    if (valid8 !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain: got v=%b, want 0", valid8);
    end
  endtask

  task automatic test_rr_full();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    out_ready = 1'b1; ei = 1'b1;
    for (int k = 7; k >= 0; k--) exp8_q.push_back(k);
    exp8_q.push_back(7);
    rr_run(8'hFF, 9);
  endtask

  task automatic test_rr_sparse();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    out_ready = 1'b1; ei = 1'b1;
    exp8_q.push_back(7); exp8_q.push_back(2); exp8_q.push_back(0);
    exp8_q.push_back(7); exp8_q.push_back(2);
    rr_run(8'b1000_0101, 5);
  endtask

  task automatic test_cascade_reset();
    ei = 1'b0; out_ready = 1'b1;
    req8 = 8'h10; req16 = 16'h0010;
    #1;
    checks++;
    if (eo8 !== 1'b0 || eo16 !== 1'b0) begin
      errors++;
      $display("FAIL cas_eo_off: got eo8=%b eo16=%b, want 0 0", eo8, eo16);
    end
    tick();
    checks++;
    if (valid8 !== 1'b0 || valid16 !== 1'b0) begin
      errors++;
      $display("FAIL cas_noload: got v8=%b v16=%b, want 0 0", valid8, valid16);
    end
    ei = 1'b1; req8 = '0; req16 = '0;
    #1;
    checks++;
    if (eo8 !== 1'b1 || eo16 !== 1'b1) begin
      errors++;
      $display("FAIL cas_eo_on: got eo8=%b eo16=%b, want 1 1", eo8, eo16);
    end
    out_ready = 1'b0; req8 = 8'h10; req16 = 16'h0010;
    exp8_q.push_back(4); exp16_q.push_back(4);
    tick();
    checks++;
    if (valid8 !== 1'b1 || y8 !== 3'(exp8_q.pop_front()) || valid16 !== 1'b1 || y16 !== 4'(exp16_q.pop_front())) begin
      errors++;
      $display("FAIL cas_load: got v8=%b y8=%0d v16=%b y16=%0d, want 1 4 1 4", valid8, y8, valid16, y16);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid8 !== 1'b0 || valid16 !== 1'b0 || y16 !== 4'd0 || grant16 !== 16'h0 || grant8 !== 8'h0) begin
      errors++;
      $display("FAIL cas_async_rst: got v8=%b v16=%b y16=%0d g16=%h g8=%h, want 0 0 0 0000 00",
               valid8, valid16, y16, grant16, grant8);
    end
    ei = 1'b1; req8 = '0; req16 = '0;
    #1;
    checks++;
    if (eo8 !== 1'b1 || eo16 !== 1'b1) begin
      errors++;
      $display("FAIL cas_eo_rst: got eo8=%b eo16=%b, want 1 1", eo8, eo16);
    end
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    checks++;
    if (valid8 !== 1'b0 || valid16 !== 1'b0) begin
      errors++;
      $display("FAIL cas_post_rst: got v8=%b v16=%b, want 0 0", valid8, valid16);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_backpressure();
    test_rr_full();
    test_rr_sparse();
    test_cascade_reset();
    checks++;
    if (exp16_q.size() != 0 || exp8_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d/%0d entries, want 0/0", exp16_q.size(), exp8_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
